touch_frame_reader: RTL and testbench
=====================================

Name: touch_frame_reader

Overview:
- Parametrised successor to the touch-panel I2C sequencer. Releases the touch controller from reset, then reads a burst of NUM_BYTES register bytes starting at START_REG over the existing I2C byte master, and stores them in an internal frame buffer.
- Operates in one-shot mode (triggered by `en`) or interrupt-poll mode (triggered by the panel's active-low INT pin).
- Adds NACK and busy-timeout error detection, which the earlier sequencer lacks.
- Presents the completed frame as a flattened bus with a one-cycle `frame_valid` strobe.

Parameters:
- DEV_ADDR, 7'h38, 7-bit I2C device address.
- START_REG, 8'h02, first register read (written as the pointer byte).
- NUM_BYTES, 6, bytes read per frame; legal range 1..32.
- RST_HOLD_CYC, 8000, cycles `touch_rst_n` is driven low after reset.
- RST_WAIT_CYC, 48000, cycles waited after release before the first transaction.
- TIMEOUT_CYC, 65535, maximum cycles any single byte transaction may take.
- CNT_W, 16, timer width; must satisfy 2^CNT_W > max(RST_HOLD_CYC, RST_WAIT_CYC, TIMEOUT_CYC).

Ports:
- clk  in  1  system clock
- reset  in  1  active-low reset
- en  in  1  one-shot frame request (level; sampled in IDLE)
- poll_mode  in  1  1 = start a frame whenever `touch_int_n` is low in IDLE
- touch_int_n  in  1  panel interrupt, active-low; double-flopped internally
- touch_rst_n  inout  1  open-drain panel reset; 0 when asserted, else high-Z
- i2c_en  out  1  request to I2C master
- i2c_rw  out  1  0 = write, 1 = read
- i2c_addr  out  7  equals DEV_ADDR constantly
- i2c_wdata  out  8  equals START_REG constantly
- i2c_busy  in  1  master busy
- i2c_nack  in  1  master NACK flag; valid on the cycle `i2c_busy` falls
- i2c_rdata  in  8  read byte; valid on the cycle `i2c_busy` falls
- frame  out  8*NUM_BYTES  byte k at bits [8k+7:8k]
- frame_valid  out  1  one-cycle strobe when `frame` has been updated
- ready  out  1  high in IDLE only
- err_nack  out  1  sticky; cleared when the next frame starts
- err_timeout  out  1  sticky; cleared when the next frame starts

Behaviour:
- Reset is asynchronous and active-low. On `reset` = 0, all outputs clear: `frame` = 0, `frame_valid`/`ready`/`err_*`/`i2c_en`/`i2c_rw` = 0. The FSM enters RST_HOLD with the timer at 0 and `touch_rst_n` driven low.
- Reset mid-transaction aborts immediately. No frame is published, and the panel reset sequence reruns.
- RST_HOLD: drive `touch_rst_n` low for RST_HOLD_CYC cycles, then go to RST_WAIT.
- RST_WAIT: release `touch_rst_n` to high-Z for RST_WAIT_CYC cycles, then go to IDLE.
- IDLE: `ready` = 1. Start a frame when `en` = 1, or when `poll_mode` = 1 and the synced INT is low. If both are true, only one frame starts.
  - Start action: clear both `err_*` flags, byte index = 0, go to PTR_REQ.
- PTR_REQ: `i2c_en` = 1, `i2c_rw` = 0. Hold both until `i2c_busy` = 1, then go to PTR_WAIT.
- PTR_WAIT: `i2c_en` stays 1 until `i2c_busy` falls.
  - On the fall: if `i2c_nack` = 1, go to ERROR; else go to RD_REQ.
- RD_REQ / RD_WAIT: same handshake with `i2c_rw` = 1.
  - On the fall with NACK: go to ERROR.
  - Otherwise: capture `i2c_rdata` into the shadow buffer at the current index.
    - If index = NUM_BYTES-1: go to PUBLISH.
    - Else: increment index and return to RD_REQ.
- PUBLISH: copy the shadow buffer to `frame` and pulse `frame_valid` for exactly one cycle, then go to DONE. `frame` is never partially updated.
- DONE: in one-shot, wait for `en` = 0, then go to IDLE. In poll mode, wait for synced INT high, then go to IDLE. This prevents retrigger on a held level.
- Timeout: the timer resets on each entry to a REQ state and counts in REQ/WAIT states. Reaching TIMEOUT_CYC sets `err_timeout` and goes to ERROR.
- ERROR: `i2c_en` = 0. `frame` and `frame_valid` are untouched. Go to RST_HOLD (full panel re-reset). Error flags remain set until the next frame starts.
- Simultaneous timeout and busy fall on the same cycle: the busy fall wins (the transaction completed).
- Index width is clog2(NUM_BYTES) with a minimum of 1. With NUM_BYTES = 1 the burst is one read and no increment occurs.

Test Plan:
- Power-up with RST_HOLD_CYC=10, RST_WAIT_CYC=20: `touch_rst_n`=0 for cycles 0..9, high-Z for the next 20 cycles, then `ready`=1 and `i2c_en`=0.
- One-shot with NUM_BYTES=6 and the model returning 0x11..0x66 → one write of 0x02 to 0x38, six reads, `frame`=48'h665544332211, exactly one `frame_valid`, no retrigger while `en` stays high.
- Poll mode with INT held low for 3 frame times → one frame only. Release INT, reassert it → second frame.
- NACK on the 3rd read → `err_nack`=1, `frame` keeps its previous value, `touch_rst_n` re-driven low, flag cleared when the next frame starts.
- Model holds `i2c_busy` high with TIMEOUT_CYC=50 → `err_timeout`=1 at cycle 50 of the wait, `i2c_en` drops, re-reset sequence runs.
- `reset` asserted during the 4th read → all outputs at reset values the same cycle, no `frame_valid` pulse.

Source files
------------

// File: rtl/touch_frame_reader.sv
// Touch-panel frame reader: resets the panel, then reads NUM_BYTES registers from
// START_REG over a byte-level I2C master and publishes them as one flattened frame.
module touch_frame_reader #(
   parameter logic [6:0] DEV_ADDR     = 7'h38,
   parameter logic [7:0] START_REG    = 8'h02,
   parameter int         NUM_BYTES    = 6,
   parameter int         RST_HOLD_CYC = 8000,
   parameter int         RST_WAIT_CYC = 48000,
   parameter int         TIMEOUT_CYC  = 65535,
   parameter int         CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic                   poll_mode,
   input  logic                   touch_int_n,
   inout  wire                    touch_rst_n,
   output logic                   i2c_en,
   output logic                   i2c_rw,
   output logic [6:0]             i2c_addr,
   output logic [7:0]             i2c_wdata,
   input  logic                   i2c_busy,
   input  logic                   i2c_nack,
   input  logic [7:0]             i2c_rdata,
   output logic [8*NUM_BYTES-1:0] frame,
   output logic                   frame_valid,
   output logic                   ready,
   output logic                   err_nack,
   output logic                   err_timeout
);

   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [3:0] {
      S_RST_HOLD, S_RST_WAIT, S_IDLE, S_PTR_REQ, S_PTR_WAIT,
      S_RD_REQ, S_RD_WAIT, S_PUBLISH, S_DONE, S_ERROR
   } state_t;

   state_t                   state_reg;
   logic [CNT_W-1:0]         timer_reg;
   logic [IDX_W-1:0]         idx_reg;
   logic                     rst_drive_reg;
   logic                     int_meta_reg;
   logic                     int_sync_reg;
   logic [7:0]               shadow_reg [NUM_BYTES];
   logic [8*NUM_BYTES-1:0]   shadow_flat;
   logic                     tmo;
   logic                     rd_ok;

   assign i2c_addr    = DEV_ADDR;
   assign i2c_wdata   = START_REG;
   assign touch_rst_n = rst_drive_reg ? 1'b0 : 1'bz;
   assign tmo         = (timer_reg == TMO_LAST);
   assign rd_ok       = (state_reg == S_RD_WAIT) && !i2c_busy && !i2c_nack;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BYTES; gi++) begin : g_flat
         assign shadow_flat[8*gi +: 8] = shadow_reg[gi];
      end
   endgenerate

   // Interrupt line idles high, so the synchroniser resets to the inactive level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         int_meta_reg <= 1'b1;
         int_sync_reg <= 1'b1;
      end else begin
         int_meta_reg <= touch_int_n;
         int_sync_reg <= int_meta_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rd_ok)
         shadow_reg[idx_reg] <= i2c_rdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_RST_HOLD;
         timer_reg     <= '0;
         idx_reg       <= '0;
         rst_drive_reg <= 1'b1;
         i2c_en        <= 1'b0;
         i2c_rw        <= 1'b0;
         frame         <= '0;
         frame_valid   <= 1'b0;
         ready         <= 1'b0;
         err_nack      <= 1'b0;
         err_timeout   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         case (state_reg)
            S_RST_HOLD: begin
               if (timer_reg == HOLD_LAST) begin
                  timer_reg     <= '0;
                  rst_drive_reg <= 1'b0;
                  state_reg     <= S_RST_WAIT;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_RST_WAIT: begin
               if (timer_reg == WAIT_LAST) begin
                  timer_reg <= '0;
                  ready     <= 1'b1;
                  state_reg <= S_IDLE;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_IDLE: begin
               if (en || (poll_mode && !int_sync_reg)) begin
                  ready       <= 1'b0;
                  err_nack    <= 1'b0;
                  err_timeout <= 1'b0;
                  idx_reg     <= '0;
                  timer_reg   <= '0;
                  i2c_en      <= 1'b1;
                  i2c_rw      <= 1'b0;
                  state_reg   <= S_PTR_REQ;
               end
            end
            S_PTR_REQ, S_RD_REQ: begin
               if (tmo) begin
                  err_timeout <= 1'b1;
                  i2c_en      <= 1'b0;
                  state_reg   <= S_ERROR;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
                  if (i2c_busy)
                     state_reg <= (state_reg == S_PTR_REQ) ? S_PTR_WAIT : S_RD_WAIT;
               end
            end
            S_PTR_WAIT, S_RD_WAIT: begin
               // A completed transaction takes priority over a coincident timeout.
               if (!i2c_busy) begin
                  if (i2c_nack) begin
                     err_nack  <= 1'b1;
                     i2c_en    <= 1'b0;
                     state_reg <= S_ERROR;
                  end else if (state_reg == S_PTR_WAIT) begin
                     timer_reg <= '0;
                     i2c_rw    <= 1'b1;
                     state_reg <= S_RD_REQ;
                  end else if (idx_reg == LAST_IDX) begin
                     i2c_en    <= 1'b0;
                     state_reg <= S_PUBLISH;
                  end else begin
                     idx_reg   <= idx_reg + 1'b1;
                     timer_reg <= '0;
                     state_reg <= S_RD_REQ;
                  end
               end else if (tmo) begin
                  err_timeout <= 1'b1;
                  i2c_en      <= 1'b0;
                  state_reg   <= S_ERROR;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            S_PUBLISH: begin
               frame       <= shadow_flat;
               frame_valid <= 1'b1;
               state_reg   <= S_DONE;
            end
            S_DONE: begin
               // Wait for the trigger level to drop so a held request reads only once.
               if (poll_mode ? int_sync_reg : !en) begin
                  ready     <= 1'b1;
                  state_reg <= S_IDLE;
               end
            end
            S_ERROR: begin
               i2c_en        <= 1'b0;
               timer_reg     <= '0;
               rst_drive_reg <= 1'b1;
               state_reg     <= S_RST_HOLD;
            end
            default: begin
               timer_reg     <= '0;
               rst_drive_reg <= 1'b1;
               state_reg     <= S_RST_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_touch_frame_reader.sv
// Scoreboard bench for touch_frame_reader: a behavioural I2C master feeds random bytes,
// a transaction-level model predicts published frames, a monitor checks them.
module tb_touch_frame_reader;

   localparam int NB = 6;
   localparam int TMO = 50;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            en = 1'b0;
   logic            poll_mode = 1'b0;
   logic            touch_int_n = 1'b1;
   wire             touch_rst_n;
   logic            i2c_en, i2c_rw;
   logic [6:0]      i2c_addr;
   logic [7:0]      i2c_wdata;
   logic            i2c_busy = 1'b0;
   logic            i2c_nack = 1'b0;
   logic [7:0]      i2c_rdata = 8'h00;
   logic [8*NB-1:0] frame;
   logic            frame_valid, ready, err_nack, err_timeout;

   pullup (touch_rst_n);

   touch_frame_reader #(
      .DEV_ADDR(7'h38), .START_REG(8'h02), .NUM_BYTES(NB),
      .RST_HOLD_CYC(10), .RST_WAIT_CYC(20), .TIMEOUT_CYC(TMO), .CNT_W(16)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .poll_mode(poll_mode), .touch_int_n(touch_int_n),
      .touch_rst_n(touch_rst_n), .i2c_en(i2c_en), .i2c_rw(i2c_rw), .i2c_addr(i2c_addr),
      .i2c_wdata(i2c_wdata), .i2c_busy(i2c_busy), .i2c_nack(i2c_nack), .i2c_rdata(i2c_rdata),
      .frame(frame), .frame_valid(frame_valid), .ready(ready), .err_nack(err_nack),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Transaction-level model state
   logic [7:0]      acc [$];
   logic [8*NB-1:0] exp_q [$];
   logic [8*NB-1:0] last_exp = '0;
   bit              ptr_ok = 0;
   bit              fixed_data = 1;
   bit              stuck = 0;
   bit              m_kill = 0;
   int              nack_read = 0;
   int              pub_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      ptr_ok = 0;
      acc.delete();
   endtask

   task automatic start_txn(input logic rw);
      chk("txn_addr", {57'd0, i2c_addr}, 64'h38);
      if (!rw) begin
         chk("ptr_wdata", {56'd0, i2c_wdata}, 64'h02);
         model_clear();
      end else begin
         chk("rd_sequence", {63'd0, (ptr_ok && acc.size() < NB)}, 64'd1);
      end
   endtask

   task automatic complete_txn(input logic rw);
      logic [7:0]      b;
      logic [8*NB-1:0] e;
      logic            nk;
      nk = rw && (nack_read != 0) && (acc.size() + 1 == nack_read);
      b  = fixed_data ? 8'(17 * (acc.size() + 1)) : 8'($urandom_range(0, 255));
      i2c_nack  = nk;
      i2c_rdata = b;
      if (!rw) begin
         ptr_ok = !nk;
      end else if (nk) begin
         model_clear();
      end else begin
         acc.push_back(b);
         if (acc.size() == NB) begin
            e = '0;
            for (int k = 0; k < NB; k++) e[8*k +: 8] = acc[k];
            exp_q.push_back(e);
            last_exp = e;
            $display("txn: frame expected %h", e);
            model_clear();
         end
      end
   endtask

   // Behavioural byte master
   initial begin : master
      int   phase = 0;
      int   dly = 0;
      int   hold = 0;
      logic rw = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!reset || m_kill) begin
            i2c_busy = 1'b0;
            i2c_nack = 1'b0;
            phase    = 0;
            m_kill   = 0;
            model_clear();
         end else begin
            case (phase)
               0: if (i2c_en) begin
                     rw = i2c_rw;
                     start_txn(rw);
                     dly   = stuck ? 0 : $urandom_range(0, 2);
                     hold  = $urandom_range(1, 5);
                     phase = 1;
                  end
               1: if (dly == 0) begin
                     i2c_busy = 1'b1;
                     phase    = 2;
                  end else begin
                     dly--;
                  end
               default: if (!stuck) begin
                     if (hold > 1) hold--;
                     else begin
                        i2c_busy = 1'b0;
                        complete_txn(rw);
                        phase = 0;
                     end
                  end
            endcase
         end
      end
   end

   // Output monitor / scoreboard
   initial begin : monitor
      logic [8*NB-1:0] prev_frame = '0;
      logic            prev_fv = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!reset) begin
            prev_frame = '0;
            prev_fv    = 1'b0;
         end else begin
            if (frame_valid) begin
               pub_cnt++;
               chk("fv_one_cycle", {63'd0, prev_fv}, 64'd0);
               if (exp_q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
               else chk("frame_data", 64'(frame), 64'(exp_q.pop_front()));
               $display("txn: frame published %h", frame);
            end else begin
               chk("frame_hold", 64'(frame), 64'(prev_frame));
            end
            prev_frame = frame;
            prev_fv    = frame_valid;
         end
      end
   end

   task automatic wait_ready(input int bound);
      int n = 0;
      while (!ready && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", {63'd0, ready}, 64'd1);
   endtask

   task automatic wait_pub(input int base, input int bound);
      int n = 0;
      while (pub_cnt <= base && n < bound) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pub_wait", {63'd0, (pub_cnt > base)}, 64'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int base, n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_frame", 64'(frame), 64'd0);
      chk("rst_outs", {58'd0, frame_valid, ready, err_nack, err_timeout, i2c_en, i2c_rw}, 64'd0);
      chk("rst_touch", {63'd0, touch_rst_n}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      // Power-up: 10 cycles held low, 20 cycles released, then ready
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         chk("pwr_touch", {63'd0, touch_rst_n}, (k < 9) ? 64'd0 : 64'd1);
         chk("pwr_ready", {63'd0, ready}, (k == 29) ? 64'd1 : 64'd0);
      end
      chk("pwr_i2c_en", {63'd0, i2c_en}, 64'd0);

      // One-shot with fixed data, en held high
      base = pub_cnt;
      en = 1'b1;
      wait_pub(base, 400);
      chk("frame_first", 64'(frame), 64'h665544332211);
      repeat (150) @(posedge clk);
      #1;
      chk("no_retrigger", pub_cnt - base, 1);
      chk("done_not_ready", {63'd0, ready}, 64'd0);
      en = 1'b0;
      wait_ready(10);
      fixed_data = 0;

      // Random one-shot frames
      for (int i = 0; i < 5; i++) begin
         wait_ready(100);
         base = pub_cnt;
         en = 1'b1;
         wait_pub(base, 400);
         en = 1'b0;
      end

      // Poll mode: held INT gives one frame, a fresh edge gives another
      wait_ready(20);
      base = pub_cnt;
      poll_mode = 1'b1;
      touch_int_n = 1'b0;
      wait_pub(base, 400);
      repeat (300) @(posedge clk);
      #1;
      chk("poll_single", pub_cnt - base, 1);
      touch_int_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("poll_rearm", {63'd0, ready}, 64'd1);
      touch_int_n = 1'b0;
      wait_pub(base + 1, 400);
      touch_int_n = 1'b1;
      chk("poll_second", pub_cnt - base, 2);
      poll_mode = 1'b0;
      wait_ready(20);

      // NACK on the third read
      nack_read = 3;
      en = 1'b1;
      n = 0;
      while (!err_nack && n < 400) begin @(posedge clk); #1; n++; end
      chk("nack_flag", {63'd0, err_nack}, 64'd1);
      chk("nack_frame_kept", 64'(frame), 64'(last_exp));
      chk("nack_i2c_en", {63'd0, i2c_en}, 64'd0);
      en = 1'b0;
      nack_read = 0;
      @(posedge clk); #1;
      chk("nack_rereset", {63'd0, touch_rst_n}, 64'd0);
      wait_ready(60);
      chk("nack_sticky", {63'd0, err_nack}, 64'd1);
      base = pub_cnt;
      en = 1'b1;
      @(posedge clk); #1;
      chk("nack_cleared", {63'd0, err_nack}, 64'd0);
      wait_pub(base, 400);
      en = 1'b0;
      wait_ready(10);

      // Busy stuck high: timeout after TMO cycles in REQ/WAIT
      stuck = 1;
      en = 1'b1;
      n = 0;
      while (!i2c_en && n < 10) begin @(posedge clk); #1; n++; end
      n = 0;
      while (!err_timeout && n < 200) begin @(posedge clk); #1; n++; end
      chk("tmo_cycles", n, TMO);
      chk("tmo_i2c_en", {63'd0, i2c_en}, 64'd0);
      en = 1'b0;
      @(posedge clk); #1;
      chk("tmo_rereset", {63'd0, touch_rst_n}, 64'd0);
      m_kill = 1;
      stuck = 0;
      wait_ready(60);
      chk("tmo_sticky", {63'd0, err_timeout}, 64'd1);

      // Reset during the fourth read
      base = pub_cnt;
      en = 1'b1;
      n = 0;
      while (!(acc.size() == 3 && i2c_busy) && n < 400) begin @(posedge clk); #1; n++; end
      chk("rst4_reached", {63'd0, (acc.size() == 3)}, 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst4_frame", 64'(frame), 64'd0);
      chk("rst4_outs", {58'd0, frame_valid, ready, err_nack, err_timeout, i2c_en, i2c_rw}, 64'd0);
      chk("rst4_touch", {63'd0, touch_rst_n}, 64'd0);
      en = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_ready(60);
      chk("rst4_no_pub", pub_cnt - base, 0);

      // Recovery frame
      base = pub_cnt;
      en = 1'b1;
      wait_pub(base, 400);
      en = 1'b0;
      wait_ready(10);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
